bus_alu_sequencer: RTL and testbench
====================================

# bus_alu_sequencer

Parametrised successor to the single-bus datapath. It combines a register file, the Y/Z staging registers, HI/LO and an ALU with an internal micro-step sequencer. Register-to-register operations no longer need a bench to drive the PCout/Yin/ZLowIn strobes: one `start` request runs the whole three-step bus sequence and signals `done`. The block sits where the hand-driven datapath sat and is the execute core for the Phase 2 control unit.

## Interface
Parameters:
- `WIDTH`, 32: data/bus width; must be a power of two, ≥ 8.
- `NREG`, 16: number of general registers; power of two, ≥ 4. `RW = log2(NREG)`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `start`  in  1  request an operation; sampled only in IDLE.
- `op`  in  3  000 add, 001 sub, 010 and, 011 or, 100 shr (logical), 101 shl, 110 mul (signed), 111 mov.
- `ra`, `rb`, `rd`  in  RW each  source A, source B, destination indices; captured with `start`.
- `ld_en`  in  1  external load request (MDR-style path); honoured only in IDLE.
- `ld_reg`  in  RW  load destination.
- `ld_data`  in  WIDTH  load value.
- `rd_sel`  in  RW  debug read select.
- `rd_data`  out  WIDTH  combinational read of `R[rd_sel]`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when an operation has committed.
- `result`  out  WIDTH  ZLow register.
- `hi_out`, `lo_out`  out  WIDTH  HI and LO registers.

## Operation
- States: IDLE → LA → EX → WB → IDLE. There are no other states. Any unreachable encoding goes to IDLE.
- IDLE, `start` = 1:
  - capture `op`, `ra`, `rb`, `rd` into internal registers;
  - next state is LA.
- LA:
  - bus = `R[ra_q]`;
  - `Y <= bus`;
  - next state is EX.
- EX:
  - bus = `R[rb_q]`;
  - `{ZHigh, ZLow} <= ALU(Y, bus)`;
  - next state is WB.
- WB:
  - mul: `HI <= ZHigh`, `LO <= ZLow`.
  - all other ops: `R[rd_q] <= ZLow`.
  - `done <= 1`.
  - next state is IDLE.
- ALU rules (Y is operand A, bus is operand B):
  - add and sub wrap modulo 2^WIDTH.
  - and and or are bitwise.
  - Shift amount = `B[log2(WIDTH)-1:0]`. Upper bits of B are ignored. shr zero-fills.
  - mul: signed WIDTH×WIDTH product, full 2·WIDTH result.
  - mov: result = A.
  - ZHigh = 0 for every op except mul.
- R0:
  - reads as 0 at all times;
  - writes to R0 (from WB or from `ld_en`) are discarded;
  - a mul with `rd` = 0 is legal, since `rd` is unused by mul.
- External load:
  - In IDLE with `ld_en` = 1: `R[ld_reg] <= ld_data` at the next edge.
  - `ld_en` is ignored while `busy`.
  - If `ld_en` and `start` arrive in the same IDLE cycle, both are accepted. LA sees the loaded value.
- `start` while `busy` is ignored. It is not queued.
- `ra` = `rb` is legal. `rd` equal to `ra` or `rb` is legal, since sources were already read in LA/EX.

## Timing
- Reset values, one edge after `clr` is sampled high:
  - `busy` = 0, `done` = 0, `result` = 0, `hi_out` = 0, `lo_out` = 0;
  - all registers, Y, ZHigh, ZLow, HI and LO = 0;
  - state = IDLE.
- `clr` wins over every other input.
- `clr` mid-operation aborts the operation: no writeback and no `done`.
- Latency, with `start` sampled at edge k:
  - `busy` is high after edges k, k+1 and k+2;
  - the writeback and the `done` pulse take effect at edge k+3;
  - `done` is high for exactly the cycle between k+3 and k+4, with `busy` = 0 in that cycle.
- Back-to-back: `start` held during the `done` cycle is accepted. Throughput is one operation per 4 cycles.
- `result` changes only at the EX edge. HI/LO change only at the WB edge of a mul.
- `rd_data` reflects a write in the cycle after the write edge.

## Test plan
- Reset: drive `clr` = 1 for 2 cycles with random inputs → `busy` = 0, `done` = 0, `result` = 0, `hi_out` = 0, `lo_out` = 0, every `rd_data` = 0.
- Add: load R3 = 0x00000005 and R5 = 0x00000003; start add, `ra` = 3, `rb` = 5, `rd` = 1 → `done` exactly 3 edges after start, R1 = 0x00000008, `result` = 0x00000008.
- Shifts: R6 = 0x80000010, R7 = 0x00000024 (amount 4).
  - shr `rd` = 2 → R2 = 0x08000001.
  - shl `rd` = 4 → R4 = 0x00000100.
- Mul and wrap:
  - R6 = 0xFFFFFFFE, R7 = 0x00000003, mul → `hi_out` = 0xFFFFFFFF, `lo_out` = 0xFFFFFFFA, no general register changed.
  - sub of R0 − R1 (R1 = 1) with `rd` = 8 → R8 = 0xFFFFFFFF.
  - Same op with `rd` = 0 → R0 still reads 0.
- Abort and ignore:
  - `start` pulsed while `busy` → no second `done`.
  - `clr` asserted during EX → no `done`, destination unchanged, `busy` = 0 next cycle.
  - `ld_en` while `busy` → target register unchanged.
- Simultaneous: in one IDLE cycle, `ld_en` (R9 = 7) plus `start` mov `ra` = 9, `rd` = 10 → R10 = 0x00000007.

Source files
------------

// File: rtl/bus_alu_sequencer.sv
// bus_alu_sequencer: register file, Y/Z/HI/LO staging and ALU run as a four-state bus sequence per start request
module bus_alu_sequencer #(
  parameter int WIDTH = 32,
  parameter int NREG = 16,
  localparam int RW = $clog2(NREG),
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [RW-1:0]    ra,
  input  logic [RW-1:0]    rb,
  input  logic [RW-1:0]    rd,
  input  logic             ld_en,
  input  logic [RW-1:0]    ld_reg,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [RW-1:0]    rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  typedef enum logic [1:0] {IDLE, LA, EX, WB} state_t;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_SHR = 3'd4, OP_SHL = 3'd5, OP_MUL = 3'd6;
  state_t state;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] y, z_hi, z_lo, hi, lo, bus, alu_lo, alu_hi;
  logic [2*WIDTH-1:0] prod;
  logic [SW-1:0] shamt;
  logic [2:0] op_q;
  logic [RW-1:0] ra_q, rb_q, rd_q;
  assign bus = regs[state == LA ? ra_q : rb_q];
  assign shamt = bus[SW-1:0];
  // low 2*WIDTH bits of the sign-extended product equal the signed product
  assign prod = {{WIDTH{y[WIDTH-1]}}, y} * {{WIDTH{bus[WIDTH-1]}}, bus};
  assign alu_lo = op_q == OP_ADD ? y + bus :
                  op_q == OP_SUB ? y - bus :
                  op_q == OP_AND ? y & bus :
                  op_q == OP_OR  ? y | bus :
                  op_q == OP_SHR ? y >> shamt :
                  op_q == OP_SHL ? y << shamt :
                  op_q == OP_MUL ? prod[WIDTH-1:0] : y;
  assign alu_hi = op_q == OP_MUL ? prod[2*WIDTH-1:WIDTH] : '0;
  assign rd_data = regs[rd_sel];
  assign busy = state != IDLE;
  assign result = z_lo;
  assign hi_out = hi;
  assign lo_out = lo;
  // R0 is never written, so it reads as zero after reset
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      done <= 1'b0;
      y <= '0;
      z_hi <= '0;
      z_lo <= '0;
      hi <= '0;
      lo <= '0;
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_en && ld_reg != '0) regs[ld_reg] <= ld_data;
          if (start) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rd_q <= rd;
            state <= LA;
          end
        end
        LA: begin
          y <= bus;
          state <= EX;
        end
        EX: begin
          z_hi <= alu_hi;
          z_lo <= alu_lo;
          state <= WB;
        end
        WB: begin
          if (op_q == OP_MUL) begin
            hi <= z_hi;
            lo <= z_lo;
          end else if (rd_q != '0) regs[rd_q] <= z_lo;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_alu_sequencer.sv
// tb_bus_alu_sequencer: random and directed ops against an arithmetic reference model with a done-driven scoreboard
module tb_bus_alu_sequencer;
  logic clk = 1'b0;
  logic clr, start, ld_en;
  logic [2:0] op;
  logic [3:0] ra, rb, rd, ld_reg, rd_sel;
  logic [31:0] ld_data, rd_data, result, hi_out, lo_out;
  logic busy, done;
  bus_alu_sequencer #(.WIDTH(32), .NREG(16)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rd(rd),
    .ld_en(ld_en), .ld_reg(ld_reg), .ld_data(ld_data), .rd_sel(rd_sel), .rd_data(rd_data),
    .busy(busy), .done(done), .result(result), .hi_out(hi_out), .lo_out(lo_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] m [16];
  logic [31:0] mhi, mlo;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", name, act, want, cyc);
    end
  endtask
  function automatic logic [63:0] alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (o)
      3'd0: return {32'b0, a + b};
      3'd1: return {32'b0, a - b};
      3'd2: return {32'b0, a & b};
      3'd3: return {32'b0, a | b};
      3'd4: return {32'b0, a >> (b % 32)};
      3'd5: return {32'b0, a << (b % 32)};
      3'd6: return sa * sb;
      default: return {32'b0, a};
    endcase
  endfunction
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got 1 want 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("result", result, e.res);
        chk("hi_out", hi_out, e.hi);
        chk("lo_out", lo_out, e.lo);
        chk("busy_in_done", {31'b0, busy}, 32'd0);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ld(input logic [3:0] r, input logic [31:0] v);
    ld_en = 1'b1;
    ld_reg = r;
    ld_data = v;
    tick;
    ld_en = 1'b0;
    if (r != 0) m[r] = v;
  endtask
  task automatic check_regs;
    for (int i = 0; i < 16; i++) begin
      rd_sel = 4'(i);
      #1;
      chk($sformatf("R%0d", i), rd_data, m[i]);
    end
  endtask
  // issues one op; inputs are scrambled while busy to show they are ignored
  task automatic op_run(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    logic [63:0] r;
    exp_t e;
    r = alu(o, m[a], m[b]);
    e.cyc = cyc + 4;
    e.res = r[31:0];
    e.hi = o == 3'd6 ? r[63:32] : mhi;
    e.lo = o == 3'd6 ? r[31:0] : mlo;
    q.push_back(e);
    op = o; ra = a; rb = b; rd = d; start = 1'b1;
    tick;
    start = 1'b0;
    ld_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy", {31'b0, busy}, 32'd1);
      start = 1'($urandom);
      ld_en = 1'($urandom);
      ld_reg = 4'($urandom);
      ld_data = $urandom;
      op = 3'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom);
      rd = 4'($urandom);
    end
    tick;
    start = 1'b0;
    ld_en = 1'b0;
    if (o == 3'd6) begin
      mhi = r[63:32];
      mlo = r[31:0];
    end else if (d != 0) m[d] = r[31:0];
  endtask
  task automatic model_reset;
    for (int i = 0; i < 16; i++) m[i] = '0;
    mhi = '0;
    mlo = '0;
  endtask
  initial begin
    model_reset();
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); ld_en = 1'($urandom); op = 3'($urandom);
      ra = 4'($urandom); rb = 4'($urandom); rd = 4'($urandom);
      ld_reg = 4'($urandom); ld_data = $urandom; rd_sel = 4'($urandom);
      tick;
    end
    clr = 1'b0; start = 1'b0; ld_en = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    check_regs();
    ld(4'd3, 32'h5);
    ld(4'd5, 32'h3);
    op_run(3'd0, 4'd3, 4'd5, 4'd1);
    chk("add_R1", m[1], 32'h8);
    ld(4'd6, 32'h80000010);
    ld(4'd7, 32'h24);
    op_run(3'd4, 4'd6, 4'd7, 4'd2);
    op_run(3'd5, 4'd6, 4'd7, 4'd4);
    check_regs();
    chk("shr_model", m[2], 32'h08000001);
    chk("shl_model", m[4], 32'h00000100);
    ld(4'd6, 32'hFFFFFFFE);
    ld(4'd7, 32'h3);
    op_run(3'd6, 4'd6, 4'd7, 4'd0);
    chk("mul_hi_model", mhi, 32'hFFFFFFFF);
    chk("mul_lo_model", mlo, 32'hFFFFFFFA);
    check_regs();
    ld(4'd1, 32'h1);
    op_run(3'd1, 4'd0, 4'd1, 4'd8);
    op_run(3'd1, 4'd0, 4'd1, 4'd0);
    ld(4'd0, 32'hDEADBEEF);
    check_regs();
    chk("sub_model", m[8], 32'hFFFFFFFF);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) ld(4'($urandom), $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom);
      op_run(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if (n % 10 == 9) check_regs();
    end
    ld(4'd12, 32'h1234);
    op = 3'd0; ra = 4'd12; rb = 4'd12; rd = 4'd12; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    repeat (4) tick;
    check_regs();
    chk("abort_result", result, 32'd0);
    ld_en = 1'b1; ld_reg = 4'd9; ld_data = 32'h7;
    m[9] = 32'h7;
    op_run(3'd7, 4'd9, 4'd3, 4'd10);
    check_regs();
    chk("simul_R10", m[10], 32'h7);
    repeat (6) tick;
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
